inst_fetch: RTL and testbench

//   Instruction-fetch sequencer on the consumer side of the PC register. It reads the

---
 rtl/inst_fetch.sv | 140 ++++++++++++++
 tb/tb_inst_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch sequencer: PC -> imem req/ack -> decode.
// Produces next sequential PC and a one-cycle PC write per fetch.
module inst_fetch #(
   parameter int WIDTH   = 16,
   parameter int PC_STEP = 2,
   parameter int TIMEOUT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] pcCur,
   output logic [WIDTH-1:0] nextInst,
   output logic             pcWrite,
   output logic             memReq,
   output logic [WIDTH-1:0] memAddr,
   input  logic             memAck,
   input  logic [WIDTH-1:0] memData,
   output logic [WIDTH-1:0] inst,
   output logic             instValid,
   input  logic             stall,
   input  logic             flush,
   output logic             fetchErr
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   localparam logic [3:0]       LP_TMO  = 4'(TIMEOUT);
   localparam logic [WIDTH-1:0] LP_STEP = WIDTH'(PC_STEP);

   state_t           r_state;
   state_t           w_next;
   logic             w_take;
   logic             w_drop;
   logic [WIDTH-1:0] r_fetchPc;
   logic [WIDTH-1:0] r_nextInst;
   logic [WIDTH-1:0] r_memAddr;
   logic [WIDTH-1:0] r_inst;
   logic             r_pcWrite;
   logic             r_memReq;
   logic             r_instValid;
   logic             r_fetchErr;
   logic             r_discard;
   logic [3:0]       r_cnt;

   always_ff @(posedge clock) begin
      if (reset) r_state <= S_REQ;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_take = 1'b0;
      w_drop = 1'b0;
      unique case (r_state)
         S_REQ: begin
            if (!flush) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (memAck) begin
               // a flush landing on the ack cycle kills the data too
               if (r_discard || flush) begin
                  w_drop = 1'b1;
                  w_next = S_REQ;
               end else begin
                  w_take = 1'b1;
                  w_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (flush || !stall) w_next = S_REQ;
         end
         default: w_next = S_REQ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetchPc   <= '0;
         r_nextInst  <= '0;
         r_memAddr   <= '0;
         r_inst      <= '0;
         r_pcWrite   <= 1'b0;
         r_memReq    <= 1'b0;
         r_instValid <= 1'b0;
         r_fetchErr  <= 1'b0;
         r_discard   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_pcWrite <= 1'b0;
         unique case (r_state)
            S_REQ: begin
               r_instValid <= 1'b0;
               if (!flush) begin
                  r_memAddr <= pcCur;
                  r_fetchPc <= pcCur;
                  r_memReq  <= 1'b1;
               end
            end
            S_WAIT: begin
               if (w_take) begin
                  r_inst      <= memData;
                  r_instValid <= 1'b1;
                  r_pcWrite   <= 1'b1;
                  r_nextInst  <= r_fetchPc + LP_STEP;
                  r_memReq    <= 1'b0;
               end else if (w_drop) begin
                  r_memReq  <= 1'b0;
                  r_discard <= 1'b0;
               end else if (flush) begin
                  r_discard <= 1'b1;
               end
               // counter saturates; the bus keeps waiting after the error
               if (memAck) begin
                  r_cnt <= '0;
               end else if (r_cnt != LP_TMO) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt + 4'd1 == LP_TMO) r_fetchErr <= 1'b1;
               end
            end
            S_HOLD: begin
               if (flush || !stall) r_instValid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign nextInst  = r_nextInst;
   assign pcWrite   = r_pcWrite;
   assign memReq    = r_memReq;
   assign memAddr   = r_memAddr;
   assign inst      = r_inst;
   assign instValid = r_instValid;
   assign fetchErr  = r_fetchErr;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed fetches queue expected
// {inst, nextInst}; a monitor pops on every pcWrite pulse.
module tb_inst_fetch;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] pcCur;
   logic [15:0] nextInst;
   logic        pcWrite;
   logic        memReq;
   logic [15:0] memAddr;
   logic        memAck;
   logic [15:0] memData;
   logic [15:0] inst;
   logic        instValid;
   logic        stall;
   logic        flush;
   logic        fetchErr;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] nxt;
   } exp_t;

   exp_t sbq[$];

   always #5 clock = ~clock;

   inst_fetch #(.WIDTH(16), .PC_STEP(2), .TIMEOUT(15)) dut (
      .clock(clock), .reset(reset), .pcCur(pcCur),
      .nextInst(nextInst), .pcWrite(pcWrite),
      .memReq(memReq), .memAddr(memAddr),
      .memAck(memAck), .memData(memData),
      .inst(inst), .instValid(instValid),
      .stall(stall), .flush(flush), .fetchErr(fetchErr)
   );

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   always @(negedge clock) begin : mon
      exp_t e;
      if (reset === 1'b0 && pcWrite === 1'b1) begin
         if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pcWrite: got 1 want 0");
         end else begin
            e = sbq.pop_front();
            chk("mon_inst", inst, e.inst);
            chk("mon_nextInst", nextInst, e.nxt);
            chk1("mon_instValid", instValid, 1'b1);
         end
      end
   end

   task automatic wait_req(input logic [15:0] pc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (memReq === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL req_timeout: got memReq=0 want memReq=1");
      end else begin
         chk("memAddr", memAddr, pc);
      end
   endtask

   task automatic fetch(input logic [15:0] pc, input logic [15:0] data,
                        input int dly, input logic [15:0] nxt);
      bit ok;
      exp_t e;
      wait_req(pc, ok);
      if (!ok) return;
      for (int i = 0; i < dly; i++) begin
         @(negedge clock);
         chk("memAddr_held", memAddr, pc);
         chk1("memReq_held", memReq, 1'b1);
      end
      memAck  = 1'b1;
      memData = data;
      e.inst  = data;
      e.nxt   = nxt;
      sbq.push_back(e);
      @(negedge clock);
      memAck = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      reset   = 1'b1;
      pcCur   = 16'h0000;
      memAck  = 1'b0;
      memData = 16'h0000;
      stall   = 1'b0;
      flush   = 1'b0;
      repeat (3) @(negedge clock);
      chk1("rst_memReq", memReq, 1'b0);
      chk("rst_memAddr", memAddr, 16'h0000);
      chk("rst_nextInst", nextInst, 16'h0000);
      chk1("rst_pcWrite", pcWrite, 1'b0);
      chk("rst_inst", inst, 16'h0000);
      chk1("rst_instValid", instValid, 1'b0);
      chk1("rst_fetchErr", fetchErr, 1'b0);

      // 1: zero-wait fetch from 0
      reset = 1'b0;
      fetch(16'h0000, 16'h1234, 0, 16'h0002);
      chk1("t1_instValid", instValid, 1'b1);
      pcCur = 16'h0040;
      @(negedge clock);
      chk1("t1_single_pulse", pcWrite, 1'b0);
      chk1("t1_valid_drop", instValid, 1'b0);

      // 2: slow memory
      fetch(16'h0040, 16'hA5A5, 5, 16'h0042);
      pcCur = 16'h0080;
      @(negedge clock);
      chk1("t2_single_pulse", pcWrite, 1'b0);

      // 3: stall in HOLD, stray ack ignored
      stall = 1'b1;
      fetch(16'h0080, 16'h1111, 0, 16'h0082);
      pcCur = 16'h00C0;
      for (int i = 0; i < 4; i++) begin
         memAck  = (i == 1);
         memData = 16'hBEEF;
         @(negedge clock);
         chk("t3_inst_hold", inst, 16'h1111);
         chk1("t3_valid_hold", instValid, 1'b1);
         chk1("t3_memReq", memReq, 1'b0);
      end
      memAck = 1'b0;
      stall  = 1'b0;
      fetch(16'h00C0, 16'h2222, 1, 16'h00C2);

      // 4: flush in WAIT, late ack discarded
      pcCur = 16'h0100;
      wait_req(16'h0100, ok);
      flush = 1'b1;
      pcCur = 16'h0200;
      @(negedge clock);
      flush = 1'b0;
      chk1("t4_memReq_kept", memReq, 1'b1);
      chk("t4_memAddr_kept", memAddr, 16'h0100);
      @(negedge clock);
      memAck  = 1'b1;
      memData = 16'hDEAD;
      @(negedge clock);
      memAck = 1'b0;
      chk("t4_inst", inst, 16'h2222);
      chk1("t4_instValid", instValid, 1'b0);
      chk1("t4_pcWrite", pcWrite, 1'b0);

      // 4b: ack and flush together
      wait_req(16'h0200, ok);
      memAck  = 1'b1;
      flush   = 1'b1;
      memData = 16'hBAD0;
      pcCur   = 16'h0300;
      @(negedge clock);
      memAck = 1'b0;
      flush  = 1'b0;
      chk("t4b_inst", inst, 16'h2222);
      chk1("t4b_instValid", instValid, 1'b0);
      fetch(16'h0300, 16'h3333, 0, 16'h0302);

      // 5: wraparound, then timeout
      pcCur = 16'hFFFE;
      fetch(16'hFFFE, 16'h4444, 0, 16'h0000);
      pcCur = 16'h0010;
      wait_req(16'h0010, ok);
      repeat (14) @(negedge clock);
      chk1("t5_err_early", fetchErr, 1'b0);
      @(negedge clock);
      chk1("t5_err_set", fetchErr, 1'b1);
      chk("t5_addr_held", memAddr, 16'h0010);
      memAck  = 1'b1;
      memData = 16'h5555;
      begin
         exp_t e;
         e.inst = 16'h5555;
         e.nxt  = 16'h0012;
         sbq.push_back(e);
      end
      @(negedge clock);
      memAck = 1'b0;
      repeat (5) @(negedge clock);
      chk1("t5_err_sticky", fetchErr, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      chk1("t5_err_reset", fetchErr, 1'b0);
      chk1("t5_valid_reset", instValid, 1'b0);
      chk1("t5_req_reset", memReq, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("sb_empty", 16'(sbq.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
